// File: rtl/fp16_pkg.sv
// Shared field constants, types and operand classification for the FP16 datapath.
package fp16_pkg;

  localparam int unsigned EXP_W  = 5;
  localparam int unsigned FRAC_W = 10;
  localparam int          BIAS   = 15;

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

  typedef enum logic [2:0] {ClsZero, ClsSub, ClsNorm, ClsInf, ClsNan} fp_class_e;

  function automatic fp_class_e classify(input fp16_t v);
    fp_class_e c;
    if (v.exp == '1) begin
      if (v.frac == '0) c = ClsInf;
      else              c = ClsNan;
    end else if (v.exp == '0) begin
      if (v.frac == '0) c = ClsZero;
      else              c = ClsSub;
    end else begin
      c = ClsNorm;
    end
    return c;
  endfunction

endpackage

// File: rtl/fp16_lzc.sv
// 10-bit leading-zero counter; an all-zero input reports 10.
module fp16_lzc (
  input  logic [9:0] val_i,
  output logic [3:0] cnt_o
);

  // Scanning upward leaves the count of the highest set bit.
  always_comb begin
    cnt_o = 4'd10;
    for (int i = 0; i < 10; i++) begin
      if (val_i[i]) cnt_o = 4'(9 - i);
    end
  end

endmodule

// File: rtl/fp16_mult.sv
// Pipelined FP16 multiplier (RNE) with ranks: operands, product, rounded result.
// Define FP16_MULT_SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to zero.
module fp16_mult
  import fp16_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  output logic [15:0] out,
  output logic [3:0]  flags
);

  if (LATENCY != 2) begin : g_latency_check
    $error("fp16_mult supports LATENCY == 2 only");
  end

  logic  v0_q;
  fp16_t a_q, b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
    end else begin
      v0_q <= in_valid;
      if (in_valid) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

  fp_class_e         cls_a, cls_b;
  logic [10:0]       ma, mb;
  logic signed [6:0] ea, eb;

`ifdef FP16_MULT_SUBNORMAL_EN
  logic [3:0] lz_a, lz_b;

  fp16_lzc u_lzc_a (.val_i(a_q.frac), .cnt_o(lz_a));
  fp16_lzc u_lzc_b (.val_i(b_q.frac), .cnt_o(lz_b));

  always_comb begin
    cls_a = classify(a_q);
    cls_b = classify(b_q);
    ma    = {1'b1, a_q.frac};
    mb    = {1'b1, b_q.frac};
    ea    = $signed({2'b00, a_q.exp});
    eb    = $signed({2'b00, b_q.exp});
    // Moving the leading one into the hidden position gives 1.f x 2^(-lz) in biased terms.
    if (cls_a == ClsSub) begin
      ma = {1'b0, a_q.frac} << (lz_a + 4'd1);
      ea = -$signed({3'b000, lz_a});
    end
    if (cls_b == ClsSub) begin
      mb = {1'b0, b_q.frac} << (lz_b + 4'd1);
      eb = -$signed({3'b000, lz_b});
    end
  end
`else
  always_comb begin
    cls_a = classify(a_q);
    cls_b = classify(b_q);
    if (cls_a == ClsSub) cls_a = ClsZero;
    if (cls_b == ClsSub) cls_b = ClsZero;
    ma = {1'b1, a_q.frac};
    mb = {1'b1, b_q.frac};
    ea = $signed({2'b00, a_q.exp});
    eb = $signed({2'b00, b_q.exp});
  end
`endif

  logic              sign_s1;
  logic signed [6:0] es_s1;
  logic [21:0]       prod_s1;
  logic              spec_hit;
  logic [15:0]       spec_out;
  logic [3:0]        spec_flags;

  assign sign_s1 = a_q.sign ^ b_q.sign;
  assign es_s1   = ea + eb - 7'(BIAS);
  assign prod_s1 = 22'(ma) * 22'(mb);

  always_comb begin
    spec_hit   = 1'b1;
    spec_out   = QNAN;
    spec_flags = 4'b0000;
    if (cls_a == ClsNan || cls_b == ClsNan) begin
      // Only a signalling NaN (quiet bit clear) raises invalid.
      spec_flags[3] = (cls_a == ClsNan && !a_q.frac[9]) || (cls_b == ClsNan && !b_q.frac[9]);
    end else if ((cls_a == ClsInf && cls_b == ClsZero) || (cls_a == ClsZero && cls_b == ClsInf)) begin
      spec_flags = 4'b1000;
    end else if (cls_a == ClsInf || cls_b == ClsInf) begin
      spec_out = POS_INF | {sign_s1, 15'b0};
    end else if (cls_a == ClsZero || cls_b == ClsZero) begin
      spec_out = {sign_s1, 15'b0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic              v1_q, sign_q, spec_hit_q;
  logic signed [6:0] es_q;
  logic [21:0]       prod_q;
  logic [15:0]       spec_out_q;
  logic [3:0]        spec_flags_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q         <= 1'b0;
      sign_q       <= 1'b0;
      es_q         <= '0;
      prod_q       <= '0;
      spec_hit_q   <= 1'b0;
      spec_out_q   <= '0;
      spec_flags_q <= '0;
    end else begin
      v1_q <= v0_q;
      if (v0_q) begin
        sign_q       <= sign_s1;
        es_q         <= es_s1;
        prod_q       <= prod_s1;
        spec_hit_q   <= spec_hit;
        spec_out_q   <= spec_out;
        spec_flags_q <= spec_flags;
      end
    end
  end

  logic [21:0]       norm, aligned;
  logic signed [6:0] exp_n;
  logic              tiny, sticky_x, g, r, s, inexact, rnd_up;
  logic [11:0]       mant_r;
  logic [5:0]        base;
  logic [16:0]       mag;
  logic [15:0]       res;
  logic [3:0]        res_flags;
`ifdef FP16_MULT_SUBNORMAL_EN
  logic [6:0]        sh;
`endif

  always_comb begin
    norm     = prod_q[21] ? prod_q : {prod_q[20:0], 1'b0};
    exp_n    = es_q + $signed({6'b0, prod_q[21]});
    tiny     = (exp_n < 7'sd1);
    aligned  = norm;
    sticky_x = 1'b0;
`ifdef FP16_MULT_SUBNORMAL_EN
    sh = 7'd1 - $unsigned(exp_n);
    if (tiny) begin
      if (sh >= 7'd22) begin
        aligned  = '0;
        sticky_x = |norm;
      end else begin
        aligned  = norm >> sh;
        sticky_x = |(norm & ~({22{1'b1}} << sh));
      end
    end
`endif
    g       = aligned[10];
    r       = aligned[9];
    s       = (|aligned[8:0]) | sticky_x;
    inexact = g | r | s;
    rnd_up  = g & (r | s | aligned[11]);
    mant_r  = {1'b0, aligned[21:11]} + {11'b0, rnd_up};
    // Adding the hidden bit onto (exp-1) lets a rounding carry bump the exponent for free.
    base      = tiny ? 6'd0 : 6'($unsigned(exp_n - 7'sd1));
    mag       = {1'b0, base, 10'b0} + {5'b0, mant_r};
    res       = {sign_q, mag[14:0]};
    res_flags = {3'b000, inexact};
    if (mag >= 17'h07C00) begin
      res       = POS_INF | {sign_q, 15'b0};
      res_flags = 4'b0101;
    end else if (tiny) begin
`ifdef FP16_MULT_SUBNORMAL_EN
      res_flags = {2'b00, inexact, inexact};
`else
      res       = {sign_q, 15'b0};
      res_flags = 4'b0011;
`endif
    end
    if (spec_hit_q) begin
      res       = spec_out_q;
      res_flags = spec_flags_q;
    end
  end

  logic        out_valid_q;
  logic [15:0] out_q;
  logic [3:0]  flags_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
      flags_q     <= '0;
    end else begin
      out_valid_q <= v1_q;
      if (v1_q) begin
        out_q   <= res;
        flags_q <= res_flags;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_fp16_mult.sv
// Directed-vector bench for fp16_mult; expectations follow FP16_MULT_SUBNORMAL_EN when defined.
module tb_fp16_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a, b;
  logic        out_valid;
  logic [15:0] out;
  logic [3:0]  flags;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  fp16_mult #(.LATENCY(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out      (out),
    .flags    (flags)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Operands sampled at edge N; result must appear only after edge N+2.
  task automatic run_op(input string tag, input logic [15:0] op_a, input logic [15:0] op_b,
                        input logic [15:0] exp_out, input logic [3:0] exp_flags);
    @(negedge clk);
    in_valid = 1'b1;
    a        = op_a;
    b        = op_b;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq({tag, " early"}, 16'(out_valid), 16'h0000);
    @(negedge clk);
    check_eq({tag, " valid"}, 16'(out_valid), 16'h0001);
    check_eq({tag, " out"}, out, exp_out);
    check_eq({tag, " flags"}, 16'(flags), 16'(exp_flags));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    #12;
    check_eq("reset out_valid", 16'(out_valid), 16'h0000);
    check_eq("reset out", out, 16'h0000);
    check_eq("reset flags", 16'(flags), 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    run_op("basic_rne", 16'h3423, 16'h3815, 16'h3039, 4'b0001);
    run_op("ovf_pos", 16'h7BFF, 16'h7BFF, 16'h7C00, 4'b0101);
    run_op("ovf_neg", 16'hFBFF, 16'h7BFF, 16'hFC00, 4'b0101);
    run_op("inf_x_zero", 16'h7C00, 16'h0000, 16'h7E00, 4'b1000);
    run_op("qnan", 16'h7E00, 16'h3C00, 16'h7E00, 4'b0000);
    run_op("snan", 16'h7C01, 16'h3C00, 16'h7E00, 4'b1000);
    run_op("inf_x_fin", 16'h7C00, 16'hC000, 16'hFC00, 4'b0000);
    run_op("zero_x_fin", 16'h0000, 16'hC500, 16'h8000, 4'b0000);
`ifdef FP16_MULT_SUBNORMAL_EN
    run_op("underflow", 16'h0400, 16'h3800, 16'h0200, 4'b0000);
    run_op("sub_input", 16'h0001, 16'h4C00, 16'h0010, 4'b0000);
`else
    run_op("underflow", 16'h0400, 16'h3800, 16'h0000, 4'b0011);
    run_op("sub_input", 16'h0001, 16'h4C00, 16'h0000, 4'b0000);
`endif

    // Back-to-back issue must give back-to-back results.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 16'h3C00;
    b        = 16'h3C00;
    @(negedge clk);
    a = 16'h4000;
    b = 16'h4200;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b first valid", 16'(out_valid), 16'h0001);
    check_eq("b2b first out", out, 16'h3C00);
    check_eq("b2b first flags", 16'(flags), 16'h0000);
    @(negedge clk);
    check_eq("b2b second valid", 16'(out_valid), 16'h0001);
    check_eq("b2b second out", out, 16'h4600);
    check_eq("b2b second flags", 16'(flags), 16'h0000);
    @(negedge clk);
    check_eq("b2b drain valid", 16'(out_valid), 16'h0000);
    check_eq("b2b hold out", out, 16'h4600);

    // Asynchronous reset with two operations in flight.
    @(negedge clk);
    in_valid = 1'b1;
    a        = 16'h3423;
    b        = 16'h3815;
    @(negedge clk);
    a = 16'h7BFF;
    b = 16'h7BFF;
    @(negedge clk);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_eq("async rst out_valid", 16'(out_valid), 16'h0000);
    check_eq("async rst out", out, 16'h0000);
    check_eq("async rst flags", 16'(flags), 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("post rst quiet valid", 16'(out_valid), 16'h0000);
      check_eq("post rst quiet out", out, 16'h0000);
    end

    run_op("after_rst", 16'h4000, 16'h4200, 16'h4600, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fp16_mult.md
Name: fp16_mult

Overview:
- Pipelined IEEE-754 binary16 (half-precision) multiplier; the multiply front-end of the FP16 MAC datapath.
- Takes two FP16 operands with a valid strobe and returns the correctly rounded FP16 product (round-to-nearest-even) plus exception flags.
- Fixed 2-cycle latency, one new operation accepted every cycle, no back-pressure.

Parameters:
- LATENCY, 2, pipeline depth from in_valid to out_valid. Only the value 2 is supported.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands a and b are valid this cycle.
- a  input  16  FP16 operand: sign[15], exponent[14:10] (bias 15), fraction[9:0].
- b  input  16  FP16 operand, same format.
- out_valid  output  1  out and flags are valid.
- out  output  16  FP16 product.
- flags  output  4  {invalid, overflow, underflow, inexact} for the operation in out.

Behaviour:
- Reset: while rst is high, out_valid=0, out=16'h0000, flags=4'b0000, and all pipeline valids are cleared. Reset takes effect immediately, not at a clock edge. An operation in flight when reset asserts is dropped.
- Latency: operands sampled at edge N with in_valid=1 produce out and out_valid=1 after edge N+2. Back-to-back inputs give back-to-back outputs.
- When out_valid=0, out and flags hold their last values.
- Stage 1:
  - Unpack and classify each operand: zero, subnormal, normal, inf or NaN.
  - Sign = a[15] XOR b[15].
  - Biased exponent sum = ea + eb - 15, computed with a signed 7-bit range.
  - 11x11 significand product with hidden bit → 22-bit product.
- Stage 2:
  - Normalise: if product bit 21 is set, shift right by 1 and increment the exponent.
  - Round to nearest even using guard, round and sticky bits. A mantissa carry out of rounding increments the exponent.
- Overflow: if the exponent is 31 or more after rounding, out = ±inf (sign<<15 | 16'h7C00), and overflow=1, inexact=1.
- Underflow: if the exponent is 0 or less, apply the underflow policy (see Optional Feature).
- Special cases, evaluated before the arithmetic:
  - Any NaN operand → out = 16'h7E00 (canonical qNaN, sign 0), invalid=1 only if that NaN is signalling (fraction bit 9 = 0).
  - inf × 0 → 16'h7E00, invalid=1.
  - inf × finite nonzero → signed inf, no flags.
  - 0 × finite → signed zero (sign is the XOR of the input signs), no flags.
- Exact results set no flags.

Optional Feature:
- Macro FP16_MULT_SUBNORMAL_EN.
- Defined: gradual underflow.
  - Subnormal inputs are normalised via a leading-zero count before multiplication.
  - Results below the normal range are shifted right into subnormal form, with sticky collected, then rounded to nearest even.
  - underflow=1 when the result is tiny and inexact.
- Undefined: flush-to-zero.
  - Subnormal inputs are treated as signed zero.
  - Any result whose exponent is 0 or less becomes signed zero, with underflow=1 and inexact=1.
- The normal-range path is identical in both builds.

Decomposition:
- Shared package fp16_pkg:
  - field width constants: EXP_W=5, FRAC_W=10, BIAS=15;
  - constants QNAN=16'h7E00, POS_INF=16'h7C00;
  - a packed struct typedef for {sign, exp, frac};
  - a class enum {ZERO, SUB, NORM, INF, NAN}.
- Sub-module fp16_lzc: 10-bit leading-zero counter, used for subnormal normalisation when FP16_MULT_SUBNORMAL_EN is defined.

Test Plan:
- a=16'h3423 (0.25854), b=16'h3815 (0.51025), in_valid=1 → two cycles later out_valid=1, out=16'h3039 (0.131958), flags=0001 (inexact).
- Back-to-back:
  - 16'h3C00×16'h3C00 → 16'h3C00, flags 0000;
  - next cycle 16'h4000×16'h4200 → 16'h4600, flags 0000;
  - the two outputs appear on consecutive cycles.
- 16'h7BFF×16'h7BFF → 16'h7C00, flags 0101. Also 16'hFBFF×16'h7BFF → 16'hFC00.
- Specials:
  - 16'h7C00×16'h0000 → 16'h7E00, flags 1000;
  - 16'h7E00×16'h3C00 → 16'h7E00, flags 0000;
  - 16'h0000×16'hC500 → 16'h8000.
- Underflow: 16'h0400×16'h3800.
  - With the macro defined → 16'h0200, flags 0000.
  - Without the macro → 16'h0000, flags 0011.
- Reset: assert rst asynchronously between edges while two operations are in flight → out_valid=0 and out=0 immediately; after rst is released, nothing is emitted until new inputs arrive.
